// File: rtl/frogger_game_ctrl.sv
// Game-flow controller for Frogger: sequences new-game/play/pause/new-frog/over
// phases and owns lives, BCD score, level and the inter-phase frame-tick wait timer.
module frogger_game_ctrl #(
    parameter int LIVES          = 3,
    parameter int LIVES_W        = 2,
    parameter int SCORE_DIGITS   = 2,
    parameter int TICK_WAIT      = 120,
    parameter int HITS_PER_LEVEL = 5,
    parameter int LEVEL_W        = 3,
    parameter int MAX_LEVEL      = 7
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      frame_tick,
    input  logic                      btn,
    input  logic                      pause_btn,
    input  logic                      hit,
    input  logic                      miss,
    output logic [2:0]                state,
    output logic                      gra_still,
    output logic [LIVES_W-1:0]        lives,
    output logic [4*SCORE_DIGITS-1:0] score,
    output logic [LEVEL_W-1:0]        level,
    output logic                      win_flash,
    output logic                      game_over
);

    localparam int TMR_W = $clog2(TICK_WAIT + 1);
    localparam int HC_W  = $clog2(HITS_PER_LEVEL + 1);

    typedef enum logic [2:0] {
        ST_NEWGAME = 3'd0,
        ST_PLAY    = 3'd1,
        ST_NEWFROG = 3'd2,
        ST_OVER    = 3'd3,
        ST_PAUSE   = 3'd4
    } state_t;

    state_t                    state_q, state_d;
    logic [TMR_W-1:0]          tmr_q, tmr_d;
    logic                      btn_q;
    logic [LIVES_W-1:0]        lives_q, lives_d;
    logic [4*SCORE_DIGITS-1:0] score_q, score_d, score_inc;
    logic [LEVEL_W-1:0]        level_q, level_d;
    logic [HC_W-1:0]           hc_q, hc_d;
    logic                      win_q, win_d;
    logic                      timer_up, btn_rise, timer_start, hit_taken;
    logic                      carry, all_nines;

    assign timer_up = (tmr_q == '0);
    assign btn_rise = btn & ~btn_q;

    // Ripple-carry BCD increment across all digits in one cycle
    always_comb begin
        carry     = 1'b1;
        score_inc = score_q;
        for (int i = 0; i < SCORE_DIGITS; i++) begin
            if (carry) begin
                if (score_q[4*i +: 4] == 4'd9) begin
                    score_inc[4*i +: 4] = 4'd0;
                end else begin
                    score_inc[4*i +: 4] = score_q[4*i +: 4] + 4'd1;
                    carry               = 1'b0;
                end
            end
        end
        all_nines = carry;
    end

    always_comb begin
        state_d     = state_q;
        lives_d     = lives_q;
        score_d     = score_q;
        level_d     = level_q;
        hc_d        = hc_q;
        timer_start = 1'b0;
        hit_taken   = 1'b0;
        case (state_q)
            ST_NEWGAME: begin
                lives_d = LIVES_W'(LIVES);
                score_d = '0;
                level_d = '0;
                hc_d    = '0;
                if (btn_rise) state_d = ST_PLAY;
            end
            ST_PLAY: begin
                if (timer_up && miss) begin
                    timer_start = 1'b1;
                    if (lives_q == LIVES_W'(1)) begin
                        lives_d = '0;
                        state_d = ST_OVER;
                    end else begin
                        lives_d = lives_q - LIVES_W'(1);
                        state_d = ST_NEWFROG;
                    end
                end else if (timer_up && hit) begin
                    timer_start = 1'b1;
                    hit_taken   = 1'b1;
                    if (!all_nines) score_d = score_inc;
                    if (hc_q == HC_W'(HITS_PER_LEVEL - 1)) begin
                        hc_d = '0;
                        if (level_q != LEVEL_W'(MAX_LEVEL)) level_d = level_q + LEVEL_W'(1);
                    end else begin
                        hc_d = hc_q + HC_W'(1);
                    end
                end else if (pause_btn) begin
                    state_d = ST_PAUSE;
                end
            end
            ST_NEWFROG: begin
                if (timer_up && btn_rise) state_d = ST_PLAY;
            end
            ST_OVER: begin
                if (timer_up) begin
                    state_d = ST_NEWGAME;
                    lives_d = LIVES_W'(LIVES);
                    score_d = '0;
                    level_d = '0;
                    hc_d    = '0;
                end
            end
            ST_PAUSE: begin
                if (pause_btn) state_d = ST_PLAY;
            end
            default: state_d = ST_NEWGAME;
        endcase

        // A tick coincident with the load is deliberately not counted
        tmr_d = tmr_q;
        if (timer_start) begin
            tmr_d = TMR_W'(TICK_WAIT);
        end else if (frame_tick && !timer_up && state_q != ST_PAUSE) begin
            tmr_d = tmr_q - TMR_W'(1);
        end

        // Looking at next-state values keeps the flag exact to the wait window
        win_d = (state_d == ST_PLAY) && (hit_taken || (win_q && tmr_d != '0));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_NEWGAME;
            tmr_q   <= '0;
            btn_q   <= 1'b0;
            lives_q <= LIVES_W'(LIVES);
            score_q <= '0;
            level_q <= '0;
            hc_q    <= '0;
            win_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            tmr_q   <= tmr_d;
            btn_q   <= btn;
            lives_q <= lives_d;
            score_q <= score_d;
            level_q <= level_d;
            hc_q    <= hc_d;
            win_q   <= win_d;
        end
    end

    assign state     = state_q;
    assign gra_still = !(state_q == ST_PLAY && timer_up);
    assign lives     = lives_q;
    assign score     = score_q;
    assign level     = level_q;
    assign win_flash = win_q;
    assign game_over = (state_q == ST_OVER);

endmodule

// File: tb/tb_frogger_game_ctrl.sv
// Directed bench for frogger_game_ctrl with default parameters.
module tb_frogger_game_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       frame_tick = 1'b0;
    logic       btn = 1'b0;
    logic       pause_btn = 1'b0;
    logic       hit = 1'b0;
    logic       miss = 1'b0;
    logic [2:0] state;
    logic       gra_still;
    logic [1:0] lives;
    logic [7:0] score;
    logic [2:0] level;
    logic       win_flash;
    logic       game_over;

    int checks = 0;
    int errors = 0;

    frogger_game_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .frame_tick (frame_tick),
        .btn        (btn),
        .pause_btn  (pause_btn),
        .hit        (hit),
        .miss       (miss),
        .state      (state),
        .gra_still  (gra_still),
        .lives      (lives),
        .score      (score),
        .level      (level),
        .win_flash  (win_flash),
        .game_over  (game_over)
    );

    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) begin
            frame_tick = 1'b1;
            step();
            frame_tick = 1'b0;
        end
    endtask

    task automatic press_btn();
        btn = 1'b1;
        step();
        btn = 1'b0;
        step();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        hit = 1'b1;
        step();
        step();
        reset = 1'b0;
        hit = 1'b0;
        checks++; if (state !== 3'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", state); end
        checks++; if (gra_still !== 1'b1) begin errors++; $display("FAIL reset_gra_still: got %b expected 1", gra_still); end
        checks++; if (lives !== 2'd3) begin errors++; $display("FAIL reset_lives: got %0d expected 3", lives); end
        checks++; if (score !== 8'h00) begin errors++; $display("FAIL reset_score: got %h expected 00", score); end
        checks++; if (level !== 3'd0) begin errors++; $display("FAIL reset_level: got %0d expected 0", level); end
        checks++; if (win_flash !== 1'b0 || game_over !== 1'b0) begin errors++; $display("FAIL reset_flags: got win=%b over=%b expected 0 0", win_flash, game_over); end
        $display("reset: state=%0d lives=%0d score=%h", state, lives, score);
    endtask

    task automatic test_start();
        btn = 1'b1;
        step();
        btn = 1'b0;
        checks++; if (state !== 3'd1) begin errors++; $display("FAIL start_state: got %0d expected 1", state); end
        checks++; if (lives !== 2'd3 || score !== 8'h00) begin errors++; $display("FAIL start_vals: got lives=%0d score=%h expected 3 00", lives, score); end
        checks++; if (gra_still !== 1'b0) begin errors++; $display("FAIL start_gra_still: got %b expected 0", gra_still); end
        step();
        $display("start: state=%0d gra_still=%b", state, gra_still);
    endtask

    task automatic test_hits();
        for (int k = 1; k <= 5; k++) begin
            hit = 1'b1;
            step();
            hit = 1'b0;
            checks++; if (score !== 8'(k)) begin errors++; $display("FAIL hit_score: hit %0d got %h expected %h", k, score, 8'(k)); end
            checks++; if (win_flash !== 1'b1 || gra_still !== 1'b1) begin errors++; $display("FAIL hit_flash: hit %0d got win=%b still=%b expected 1 1", k, win_flash, gra_still); end
            checks++; if (level !== 3'(k / 5)) begin errors++; $display("FAIL hit_level: hit %0d got %0d expected %0d", k, level, k / 5); end
            hit = 1'b1;
            step();
            hit = 1'b0;
            checks++; if (score !== 8'(k)) begin errors++; $display("FAIL hit_in_wait: got %h expected %h", score, 8'(k)); end
            tick_n(119);
            checks++; if (win_flash !== 1'b1 || gra_still !== 1'b1) begin errors++; $display("FAIL wait_119: got win=%b still=%b expected 1 1", win_flash, gra_still); end
            tick_n(1);
            checks++; if (win_flash !== 1'b0 || gra_still !== 1'b0) begin errors++; $display("FAIL wait_120: got win=%b still=%b expected 0 0", win_flash, gra_still); end
            $display("hit %0d: score=%h level=%0d", k, score, level);
        end
    endtask

    task automatic test_saturation();
        int s;
        logic [7:0] exp_score;
        logic [2:0] exp_level;
        for (int n = 6; n <= 100; n++) begin
            hit = 1'b1;
            step();
            hit = 1'b0;
            s = (n > 99) ? 99 : n;
            exp_score = 8'((s / 10) * 16 + (s % 10));
            exp_level = 3'((n / 5 > 7) ? 7 : n / 5);
            checks++; if (score !== exp_score) begin errors++; $display("FAIL sat_score: hit %0d got %h expected %h", n, score, exp_score); end
            checks++; if (level !== exp_level) begin errors++; $display("FAIL sat_level: hit %0d got %0d expected %0d", n, level, exp_level); end
            $display("hit %0d: score=%h level=%0d", n, score, level);
            tick_n(120);
        end
    endtask

    task automatic test_hit_miss_same();
        hit = 1'b1;
        miss = 1'b1;
        step();
        hit = 1'b0;
        miss = 1'b0;
        checks++; if (lives !== 2'd2) begin errors++; $display("FAIL hm_lives: got %0d expected 2", lives); end
        checks++; if (score !== 8'h99) begin errors++; $display("FAIL hm_score: got %h expected 99", score); end
        checks++; if (state !== 3'd2 || win_flash !== 1'b0) begin errors++; $display("FAIL hm_state: got state=%0d win=%b expected 2 0", state, win_flash); end
        press_btn();
        checks++; if (state !== 3'd2) begin errors++; $display("FAIL early_btn: got %0d expected 2", state); end
        tick_n(120);
        checks++; if (state !== 3'd2) begin errors++; $display("FAIL newfrog_hold: got %0d expected 2", state); end
        btn = 1'b1;
        step();
        btn = 1'b0;
        checks++; if (state !== 3'd1) begin errors++; $display("FAIL newfrog_play: got %0d expected 1", state); end
        step();
        $display("hit+miss: lives=%0d score=%h state=%0d", lives, score, state);
    endtask

    task automatic test_game_over();
        miss = 1'b1;
        step();
        miss = 1'b0;
        checks++; if (lives !== 2'd1 || state !== 3'd2) begin errors++; $display("FAIL miss2: got lives=%0d state=%0d expected 1 2", lives, state); end
        tick_n(120);
        press_btn();
        miss = 1'b1;
        step();
        miss = 1'b0;
        checks++; if (lives !== 2'd0 || state !== 3'd3 || game_over !== 1'b1) begin errors++; $display("FAIL over: got lives=%0d state=%0d over=%b expected 0 3 1", lives, state, game_over); end
        checks++; if (score !== 8'h99 || level !== 3'd7) begin errors++; $display("FAIL over_hold: got score=%h level=%0d expected 99 7", score, level); end
        tick_n(120);
        checks++; if (state !== 3'd3) begin errors++; $display("FAIL over_wait: got %0d expected 3", state); end
        step();
        checks++; if (state !== 3'd0 || game_over !== 1'b0) begin errors++; $display("FAIL newgame: got state=%0d over=%b expected 0 0", state, game_over); end
        checks++; if (score !== 8'h00 || level !== 3'd0 || lives !== 2'd3) begin errors++; $display("FAIL newgame_clear: got score=%h level=%0d lives=%0d expected 00 0 3", score, level, lives); end
        $display("game over: state=%0d score=%h", state, score);
    endtask

    task automatic test_pause();
        press_btn();
        hit = 1'b1;
        step();
        hit = 1'b0;
        tick_n(70);
        pause_btn = 1'b1;
        step();
        pause_btn = 1'b0;
        checks++; if (state !== 3'd4 || gra_still !== 1'b1 || win_flash !== 1'b0) begin errors++; $display("FAIL pause_enter: got state=%0d still=%b win=%b expected 4 1 0", state, gra_still, win_flash); end
        tick_n(20);
        hit = 1'b1;
        miss = 1'b1;
        step();
        hit = 1'b0;
        miss = 1'b0;
        checks++; if (state !== 3'd4 || score !== 8'h01 || lives !== 2'd3) begin errors++; $display("FAIL pause_ignore: got state=%0d score=%h lives=%0d expected 4 01 3", state, score, lives); end
        pause_btn = 1'b1;
        step();
        pause_btn = 1'b0;
        checks++; if (state !== 3'd1 || gra_still !== 1'b1) begin errors++; $display("FAIL pause_exit: got state=%0d still=%b expected 1 1", state, gra_still); end
        tick_n(49);
        checks++; if (gra_still !== 1'b1) begin errors++; $display("FAIL resume_49: got %b expected 1", gra_still); end
        tick_n(1);
        checks++; if (gra_still !== 1'b0) begin errors++; $display("FAIL resume_50: got %b expected 0", gra_still); end
        $display("pause: state=%0d gra_still=%b", state, gra_still);
    endtask

    task automatic test_reset_in_pause();
        hit = 1'b1;
        step();
        hit = 1'b0;
        tick_n(10);
        pause_btn = 1'b1;
        step();
        pause_btn = 1'b0;
        checks++; if (state !== 3'd4 || score !== 8'h02) begin errors++; $display("FAIL pre_reset: got state=%0d score=%h expected 4 02", state, score); end
        reset = 1'b1;
        pause_btn = 1'b1;
        hit = 1'b1;
        step();
        reset = 1'b0;
        pause_btn = 1'b0;
        hit = 1'b0;
        checks++; if (state !== 3'd0 || gra_still !== 1'b1 || game_over !== 1'b0 || win_flash !== 1'b0) begin errors++; $display("FAIL rst_pause_state: got state=%0d still=%b over=%b win=%b expected 0 1 0 0", state, gra_still, game_over, win_flash); end
        checks++; if (score !== 8'h00 || lives !== 2'd3 || level !== 3'd0) begin errors++; $display("FAIL rst_pause_vals: got score=%h lives=%0d level=%0d expected 00 3 0", score, lives, level); end
        btn = 1'b1;
        step();
        btn = 1'b0;
        checks++; if (state !== 3'd1 || gra_still !== 1'b0) begin errors++; $display("FAIL rst_timer: got state=%0d still=%b expected 1 0", state, gra_still); end
        $display("reset in pause: state=%0d score=%h", state, score);
    endtask

    initial begin
        test_reset();
        test_start();
        test_hits();
        test_saturation();
        test_hit_miss_same();
        test_game_over();
        test_pause();
        test_reset_in_pause();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
